// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: one-hot T-state ring, control matrix, HLT latch
// and program/run gating of SRAM access.
module controller_sequencer #(
  parameter bit SKIP_NOP_STATES = 1'b0
) (
  input  logic       clk,
  input  logic       clear_bar,
  input  logic       run_not_prog,
  input  logic       prog_we,
  input  logic       lda,
  input  logic       add,
  input  logic       sub,
  input  logic       out,
  input  logic       hlt,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_bar,
  output logic       ce_bar,
  output logic       we_bar,
  output logic       Li_bar,
  output logic       Ei_bar,
  output logic       La_bar,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_bar,
  output logic       Lo_bar,
  output logic [5:0] t_state,
  output logic       halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e state_r;
  t_state_e state_nxt_s;
  logic     halted_r;
  logic     halted_nxt_s;

  logic sel_hlt_s;
  logic sel_lda_s;
  logic sel_add_s;
  logic sel_sub_s;
  logic sel_out_s;
  logic sel_nop_s;

  // Priority decode of the instruction flags: hlt > lda > add > sub > out.
  always_comb begin
    sel_hlt_s = hlt;
    sel_lda_s = ~hlt & lda;
    sel_add_s = ~hlt & ~lda & add;
    sel_sub_s = ~hlt & ~lda & ~add & sub;
    sel_out_s = ~hlt & ~lda & ~add & ~sub & out;
    sel_nop_s = ~(hlt | lda | add | sub | out);
  end

  // State and halt registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clear_bar) begin
      state_r  <= T1;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  // Ring advance; halt freezes the ring at T4, program mode parks it at T1.
  always_comb begin
    state_nxt_s  = state_r;
    halted_nxt_s = halted_r;
    if (halted_r) begin
      state_nxt_s = state_r;
    end else if (!run_not_prog) begin
      state_nxt_s = T1;
    end else begin
      case (state_r)
        T1: state_nxt_s = T2;
        T2: state_nxt_s = T3;
        T3: state_nxt_s = (SKIP_NOP_STATES && sel_nop_s) ? T1 : T4;
        T4: begin
          if (sel_hlt_s) begin
            state_nxt_s  = T4;
            halted_nxt_s = 1'b1;
          end else if (SKIP_NOP_STATES && sel_out_s) begin
            state_nxt_s = T1;
          end else begin
            state_nxt_s = T5;
          end
        end
        T5: state_nxt_s = (SKIP_NOP_STATES && sel_lda_s) ? T1 : T6;
        T6: state_nxt_s = T1;
        default: state_nxt_s = T1;
      endcase
    end
  end

  // Control matrix; clear dominates, then program mode, then halt.
  always_comb begin
    Cp     = 1'b0;
    Ep     = 1'b0;
    Lm_bar = 1'b1;
    ce_bar = 1'b1;
    we_bar = 1'b1;
    Li_bar = 1'b1;
    Ei_bar = 1'b1;
    La_bar = 1'b1;
    Ea     = 1'b0;
    Su     = 1'b0;
    Eu     = 1'b0;
    Lb_bar = 1'b1;
    Lo_bar = 1'b1;
    if (!clear_bar) begin
      Cp = 1'b0;
    end else if (!run_not_prog) begin
      ce_bar = ~prog_we;
      we_bar = ~prog_we;
    end else if (halted_r) begin
      Cp = 1'b0;
    end else begin
      case (state_r)
        T1: begin
          Ep     = 1'b1;
          Lm_bar = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          ce_bar = 1'b0;
          Li_bar = 1'b0;
        end
        T4: begin
          if (sel_lda_s || sel_add_s || sel_sub_s) begin
            Ei_bar = 1'b0;
            Lm_bar = 1'b0;
          end else if (sel_out_s) begin
            Ea     = 1'b1;
            Lo_bar = 1'b0;
          end else begin
            Ea = 1'b0;
          end
        end
        T5: begin
          if (sel_lda_s) begin
            ce_bar = 1'b0;
            La_bar = 1'b0;
          end else if (sel_add_s || sel_sub_s) begin
            ce_bar = 1'b0;
            Lb_bar = 1'b0;
          end else begin
            ce_bar = 1'b1;
          end
        end
        T6: begin
          if (sel_add_s || sel_sub_s) begin
            Eu     = 1'b1;
            Su     = sel_sub_s;
            La_bar = 1'b0;
          end else begin
            Eu = 1'b0;
          end
        end
        default: Cp = 1'b0;
      endcase
    end
  end

  assign t_state = state_r;
  assign halted  = halted_r;

endmodule

// File: tb/tb_controller_sequencer.sv
// Randomized bench for controller_sequencer: two instances (SKIP 0 and 1)
// compared every cycle against an instruction-level step model.
module tb_controller_sequencer;

  localparam int K_NOP = 0;
  localparam int K_LDA = 1;
  localparam int K_ADD = 2;
  localparam int K_SUB = 3;
  localparam int K_OUT = 4;
  localparam int K_HLT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear_bar, run_not_prog, prog_we, lda, add, sub, out, hlt;
  logic [1:0] cp, ep, lm, ce, we, li, ei, la, ea, su, eu, lb, lo, hl;
  logic [5:0] ts [2];

  int n_checks = 0;
  int n_fail   = 0;
  int step [2];
  bit hm   [2];

  controller_sequencer #(.SKIP_NOP_STATES(1'b0)) dut0 (
    .clk(clk), .clear_bar(clear_bar), .run_not_prog(run_not_prog), .prog_we(prog_we),
    .lda(lda), .add(add), .sub(sub), .out(out), .hlt(hlt),
    .Cp(cp[0]), .Ep(ep[0]), .Lm_bar(lm[0]), .ce_bar(ce[0]), .we_bar(we[0]),
    .Li_bar(li[0]), .Ei_bar(ei[0]), .La_bar(la[0]), .Ea(ea[0]), .Su(su[0]),
    .Eu(eu[0]), .Lb_bar(lb[0]), .Lo_bar(lo[0]), .t_state(ts[0]), .halted(hl[0])
  );

  controller_sequencer #(.SKIP_NOP_STATES(1'b1)) dut1 (
    .clk(clk), .clear_bar(clear_bar), .run_not_prog(run_not_prog), .prog_we(prog_we),
    .lda(lda), .add(add), .sub(sub), .out(out), .hlt(hlt),
    .Cp(cp[1]), .Ep(ep[1]), .Lm_bar(lm[1]), .ce_bar(ce[1]), .we_bar(we[1]),
    .Li_bar(li[1]), .Ei_bar(ei[1]), .La_bar(la[1]), .Ea(ea[1]), .Su(su[1]),
    .Eu(eu[1]), .Lb_bar(lb[1]), .Lo_bar(lo[1]), .t_state(ts[1]), .halted(hl[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic l, input logic a, input logic s,
                                 input logic o, input logic h);
    if (h) return K_HLT;
    if (l) return K_LDA;
    if (a) return K_ADD;
    if (s) return K_SUB;
    if (o) return K_OUT;
    return K_NOP;
  endfunction

  // Number of T-states an instruction occupies before returning to T1.
  function automatic int instr_len(input int k, input int skip);
    if (skip == 0) return 6;
    case (k)
      K_NOP:   return 3;
      K_OUT:   return 4;
      K_LDA:   return 5;
      default: return 6;
    endcase
  endfunction

  // Expected {Cp,Ep,Lm_bar,ce_bar,we_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}.
  function automatic logic [12:0] exp_cw(input int st, input int k, input bit h,
                                         input logic clr, input logic run, input logic pwe);
    bit c = 0, e = 0, lmb = 1, ceb = 1, web = 1, lib = 1, eib = 1;
    bit lab = 1, a = 0, s = 0, u = 0, lbb = 1, lob = 1;
    if (clr && !run) begin
      ceb = !pwe;
      web = !pwe;
    end else if (clr && !h) begin
      if (st == 1) begin e = 1; lmb = 0; end
      if (st == 2) c = 1;
      if (st == 3) begin ceb = 0; lib = 0; end
      if (st == 4 && (k == K_LDA || k == K_ADD || k == K_SUB)) begin eib = 0; lmb = 0; end
      if (st == 4 && k == K_OUT) begin a = 1; lob = 0; end
      if (st == 5 && k == K_LDA) begin ceb = 0; lab = 0; end
      if (st == 5 && (k == K_ADD || k == K_SUB)) begin ceb = 0; lbb = 0; end
      if (st == 6 && (k == K_ADD || k == K_SUB)) begin u = 1; lab = 0; s = (k == K_SUB); end
    end
    return {c, e, lmb, ceb, web, lib, eib, lab, a, s, u, lbb, lob};
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int k;
    @(negedge clk);
    k = kind_of(lda, add, sub, out, hlt);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("tstate%0d", i), 32'(ts[i]), 32'd1 << (step[i] - 1));
      check_eq($sformatf("halted%0d", i), 32'(hl[i]), 32'(hm[i]));
      check_eq($sformatf("ctl%0d", i),
               32'({cp[i], ep[i], lm[i], ce[i], we[i], li[i], ei[i], la[i], ea[i],
                    su[i], eu[i], lb[i], lo[i]}),
               32'(exp_cw(step[i], k, hm[i], clear_bar, run_not_prog, prog_we)));
      check_eq($sformatf("bus%0d", i),
               32'($countones({ep[i], ~ei[i], ea[i], eu[i], ~ce[i] & run_not_prog}) > 1),
               32'd0);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!clear_bar) begin
        step[i] = 1;
        hm[i]   = 0;
      end else if (hm[i]) begin
        hm[i] = 1;
      end else if (!run_not_prog) begin
        step[i] = 1;
      end else if (step[i] == 4 && k == K_HLT) begin
        hm[i] = 1;
      end else if (step[i] == 6 || step[i] == instr_len(k, i)) begin
        step[i] = 1;
      end else begin
        step[i] = step[i] + 1;
      end
    end
    #1;
  endtask

  task automatic set_flags(input logic [4:0] f);
    {lda, add, sub, out, hlt} = f;
  endtask

  function automatic logic [4:0] rand_flags();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    case ($urandom_range(0, 5))
      0:       return 5'b00000;
      1:       return 5'b10000;
      2:       return 5'b01000;
      3:       return 5'b00100;
      4:       return 5'b00010;
      default: return 5'b00001;
    endcase
  endfunction

  task automatic run_seg(input logic [4:0] f, input int n);
    clear_bar = 1'b1;
    run_not_prog = 1'b1;
    prog_we = 1'b0;
    set_flags(f);
    for (int j = 0; j < n; j++) cycle();
  endtask

  initial begin
    clear_bar = 1'b0;
    run_not_prog = 1'b1;
    prog_we = 1'b0;
    set_flags(5'b00000);
    @(posedge clk);
    @(posedge clk);
    #1;
    step[0] = 1; step[1] = 1;
    hm[0] = 0;   hm[1] = 0;
    cycle();

    run_seg(5'b00000, 14);
    run_seg(5'b10000, 12);
    run_seg(5'b00100, 12);
    run_seg(5'b01000, 12);
    run_seg(5'b11000, 12);
    run_seg(5'b00010, 12);
    run_seg(5'b00001, 16);
    clear_bar = 1'b0;
    cycle();
    clear_bar = 1'b1;
    run_not_prog = 1'b0;
    prog_we = 1'b1;
    for (int j = 0; j < 3; j++) cycle();
    prog_we = 1'b0;
    for (int j = 0; j < 2; j++) cycle();
    run_seg(5'b10000, 5);
    clear_bar = 1'b0;
    cycle();
    run_seg(5'b00100, 8);

    for (int seg = 0; seg < 300; seg++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        run_seg(rand_flags(), int'($urandom_range(1, 18)));
      end else if (r <= 7) begin
        clear_bar = 1'b1;
        run_not_prog = 1'b0;
        set_flags(rand_flags());
        for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
          prog_we = 1'($urandom);
          cycle();
        end
      end else begin
        clear_bar = 1'b0;
        run_not_prog = 1'($urandom);
        prog_we = 1'($urandom);
        set_flags(rand_flags());
        for (int j = 0; j < int'($urandom_range(1, 2)); j++) cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
